fifo_stream_reader: RTL and testbench

- Downstream consumer of the dual-clock `fifo` read port, running entirely in the read clock domain.
- Drains the FIFO through its REN/EMPTY/R_DATA interface and re-presents the data as a VALID/READY stream.
- Absorbs the FIFO's fixed read latency with a small credit-controlled buffer, so no word is lost or duplicated under back-pressure.
- Sustains one word per cycle when the consumer is always ready.

---
 rtl/fifo_stream_pkg.sv | 24 ++
 rtl/sfifo_buf.sv | 69 ++++++
 rtl/fifo_stream_reader.sv | 102 ++++++++++
 tb/tb_fifo_stream_reader.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_stream_pkg.sv
// ---------------------------------------------------------------------------
// fifo_stream_pkg : shared constants and helpers for fifo_stream_reader (rev 1.0)
// ---------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

package fifo_stream_pkg;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 2;

  // Bits needed to hold any value in 0..n inclusive.
  function automatic int clog2p1(input int n);
    int w;
    w = 1;
    while ((1 << w) <= n) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sfifo_buf.sv
// ---------------------------------------------------------------------------
// sfifo_buf : single-clock synchronous FIFO, any DEPTH >= 1 (rev 1.0)
// ---------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module sfifo_buf
  import fifo_stream_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic [DATA_WIDTH-1:0]        push_data,
  input  logic                         pop,
  output logic [DATA_WIDTH-1:0]        pop_data,
  output logic [clog2p1(DEPTH)-1:0]    count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = clog2p1(DEPTH);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]         r_rd_ptr;
  logic [PW-1:0]         r_wr_ptr;
  logic                  w_pop;
  logic                  w_push;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) begin
      return '0;
    end
    return p + PW'(1);
  endfunction

  assign w_pop    = pop && (count != '0);
  assign w_push   = push && ((count != CW'(DEPTH)) || w_pop);
  assign pop_data = r_mem[r_rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      count    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= push_data;
        r_wr_ptr        <= next_ptr(r_wr_ptr);
      end
      if (w_pop) begin
        r_rd_ptr <= next_ptr(r_rd_ptr);
      end
      case ({w_push, w_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/fifo_stream_reader.sv
// ---------------------------------------------------------------------------
// fifo_stream_reader : drains a fixed-latency FIFO read port into VALID/READY.
// Optional BEAT_CNT/UNDERRUN outputs with FIFO_STREAM_READER_CNT_EN (rev 1.0)
// ---------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module fifo_stream_reader
  import fifo_stream_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int RD_LATENCY = 1,
  parameter int BUF_DEPTH  = RD_LATENCY + 1
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              f_empty,
  output logic                              f_ren,
  input  logic [DATA_WIDTH-1:0]             f_rdata,
  output logic                              m_valid,
  input  logic                              m_ready,
  output logic [DATA_WIDTH-1:0]             m_data,
  output logic [clog2p1(BUF_DEPTH)-1:0]     level
`ifdef FIFO_STREAM_READER_CNT_EN
  ,
  output logic [31:0]                       beat_cnt,
  output logic                              underrun
`endif
);

  localparam int IW = clog2p1(RD_LATENCY);
  localparam int SW = clog2p1(BUF_DEPTH + RD_LATENCY);

  if ((RD_LATENCY < RD_LAT_MIN) || (RD_LATENCY > RD_LAT_MAX)) begin : g_bad_latency
    $error("fifo_stream_reader: RD_LATENCY out of range");
  end
  if (BUF_DEPTH < RD_LATENCY + 1) begin : g_bad_depth
    $error("fifo_stream_reader: BUF_DEPTH must be at least RD_LATENCY+1");
  end

  logic [RD_LATENCY-1:0] r_pipe;
  logic [IW-1:0]         w_inflight;
  logic [SW-1:0]         w_committed;
  logic                  w_pop;
  logic                  w_push;

  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < RD_LATENCY; i++) begin
      w_inflight = w_inflight + IW'(r_pipe[i]);
    end
  end

  assign w_pop  = m_valid & m_ready;
  assign w_push = r_pipe[RD_LATENCY-1];

  // Credit: buffered plus in-flight words, less the one leaving now, must
  // leave room for the read being requested.
  assign w_committed = SW'(level) + SW'(w_inflight) - SW'(w_pop);
  assign f_ren       = ~f_empty & rst_n & (w_committed < SW'(BUF_DEPTH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pipe <= '0;
    end else begin
      r_pipe[0] <= f_ren;
      for (int i = 1; i < RD_LATENCY; i++) begin
        r_pipe[i] <= r_pipe[i-1];
      end
    end
  end

  sfifo_buf #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (BUF_DEPTH)
  ) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (w_push),
    .push_data (f_rdata),
    .pop       (w_pop),
    .pop_data  (m_data),
    .count     (level)
  );

  assign m_valid = (level != '0);

`ifdef FIFO_STREAM_READER_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt <= '0;
      underrun <= 1'b0;
    end else begin
      beat_cnt <= beat_cnt + 32'(w_pop);
      underrun <= m_ready & ~m_valid & f_empty;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_fifo_stream_reader.sv
// ---------------------------------------------------------------------------
// tb_fifo_stream_reader : directed bench, RD_LATENCY=1 and 2 instances in lockstep (rev 1.0)
// ---------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_fifo_stream_reader;

  localparam int DW   = 8;
  localparam int NDUT = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          m_ready;
  logic          force_empty;
  logic          f_empty [NDUT];
  logic          f_ren   [NDUT];
  logic [DW-1:0] f_rdata [NDUT];
  logic          m_valid [NDUT];
  logic [DW-1:0] m_data  [NDUT];
  logic [1:0]    level   [NDUT];
`ifdef FIFO_STREAM_READER_CNT_EN
  logic [31:0]   beat_cnt [NDUT];
  logic          underrun [NDUT];
`endif

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    fifo_stream_reader #(
      .DATA_WIDTH (DW),
      .RD_LATENCY (g + 1)
    ) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .f_empty  (f_empty[g]),
      .f_ren    (f_ren[g]),
      .f_rdata  (f_rdata[g]),
      .m_valid  (m_valid[g]),
      .m_ready  (m_ready),
      .m_data   (m_data[g]),
      .level    (level[g])
`ifdef FIFO_STREAM_READER_CNT_EN
      ,
      .beat_cnt (beat_cnt[g]),
      .underrun (underrun[g])
`endif
    );
  end

  int n_tests = 0;
  int n_fail  = 0;
  int cyc;
  int src_len;
  logic [7:0] base;

  int         src_idx   [NDUT];
  logic       sched_v   [NDUT][4];
  logic [7:0] sched_d   [NDUT][4];
  logic [7:0] expq      [NDUT][$];
  logic       pushing   [NDUT];
  logic       prev_hold [NDUT];
  logic [7:0] prev_data [NDUT];
  int         pops      [NDUT];

  logic       s_ren   [NDUT];
  logic       s_valid [NDUT];
  logic [7:0] s_data  [NDUT];
  logic [1:0] s_level [NDUT];
`ifdef FIFO_STREAM_READER_CNT_EN
  logic [31:0] s_beat  [NDUT];
  logic        s_under [NDUT];
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic clear_model();
    for (int g = 0; g < NDUT; g++) begin
      src_idx[g]   = 0;
      pushing[g]   = 1'b0;
      prev_hold[g] = 1'b0;
      prev_data[g] = '0;
      pops[g]      = 0;
      expq[g].delete();
      for (int s = 0; s < 4; s++) begin
        sched_v[g][s] = 1'b0;
        sched_d[g][s] = '0;
      end
    end
  endtask

  // One read-clock cycle: drive at negedge, sample 1ns later, model the FIFO.
  task automatic tick();
    for (int g = 0; g < NDUT; g++) begin
      int slot;
      slot          = cyc % 4;
      pushing[g]    = sched_v[g][slot];
      f_rdata[g]    = sched_v[g][slot] ? sched_d[g][slot] : 8'hEE;
      sched_v[g][slot] = 1'b0;
      f_empty[g]    = force_empty | (src_idx[g] >= src_len);
    end
    #1;
    for (int g = 0; g < NDUT; g++) begin
      logic       pop;
      logic [7:0] w;
      s_ren[g]   = f_ren[g];
      s_valid[g] = m_valid[g];
      s_data[g]  = m_data[g];
      s_level[g] = level[g];
`ifdef FIFO_STREAM_READER_CNT_EN
      s_beat[g]  = beat_cnt[g];
      s_under[g] = underrun[g];
`endif
      pop = m_valid[g] & m_ready;
      if (rst_n) begin
        if (prev_hold[g]) begin
          chk("hold_valid", m_valid[g], 1);
          chk("hold_data", m_data[g], prev_data[g]);
        end
        chk("push_while_full", pushing[g] && (level[g] == 2'(g + 2)) && !pop, 0);
        if (f_ren[g]) chk("ren_while_empty", f_empty[g], 0);
        if (pop) begin
          chk("pop_has_expected", expq[g].size() != 0, 1);
          if (expq[g].size() != 0) chk("order", m_data[g], expq[g].pop_front());
          pops[g]++;
        end
        if (f_ren[g]) begin
          w = base + 8'(src_idx[g]);
          sched_v[g][(cyc + g + 1) % 4] = 1'b1;
          sched_d[g][(cyc + g + 1) % 4] = w;
          expq[g].push_back(w);
          src_idx[g]++;
        end
        prev_hold[g] = m_valid[g] & ~pop;
        prev_data[g] = m_data[g];
      end
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_reset(input int hold);
    rst_n = 1'b0;
    clear_model();
    for (int i = 0; i < hold; i++) begin
      tick();
      for (int g = 0; g < NDUT; g++) begin
        chk("rst_ren", s_ren[g], 0);
        chk("rst_valid", s_valid[g], 0);
        chk("rst_level", s_level[g], 0);
        chk("rst_data", s_data[g], 0);
`ifdef FIFO_STREAM_READER_CNT_EN
        chk("rst_beat", s_beat[g], 0);
        chk("rst_under", s_under[g], 0);
`endif
      end
    end
    rst_n = 1'b1;
    cyc   = 0;
  endtask

  initial begin
    rst_n       = 1'b0;
    m_ready     = 1'b1;
    force_empty = 1'b1;
    src_len     = 0;
    base        = 8'h00;
    cyc         = 0;
    clear_model();
    for (int g = 0; g < NDUT; g++) begin
      f_empty[g] = 1'b1;
      f_rdata[g] = '0;
    end
    @(negedge clk);

    // Idle: empty FIFO, ready consumer.
    do_reset(3);
    for (int c = 0; c < 20; c++) begin
      tick();
      for (int g = 0; g < NDUT; g++) begin
        chk("t1_ren", s_ren[g], 0);
        chk("t1_valid", s_valid[g], 0);
        chk("t1_level", s_level[g], 0);
      end
    end

    // Full-rate stream of 0x00..0x0F.
    force_empty = 1'b0;
    src_len     = 16;
    base        = 8'h00;
    do_reset(2);
    for (int c = 0; c < 22; c++) begin
      tick();
      for (int g = 0; g < NDUT; g++) begin
        logic v;
        v = (c >= g + 2) && (c < g + 18);
        chk("t2_ren", s_ren[g], c < 16);
        chk("t2_valid", s_valid[g], v);
        if (v) chk("t2_data", s_data[g], c - (g + 2));
      end
    end

    // Consumer stall at word 3 for 10 cycles.
    do_reset(2);
    for (int c = 0; c < 30; c++) begin
      m_ready = !((c >= 5) && (c < 15));
      tick();
      if ((c >= 5) && (c < 15)) begin
        chk("t3_ren_stalled", s_ren[0], 0);
        chk("t3_valid_stalled", s_valid[0], 1);
        chk("t3_data_stalled", s_data[0], 8'h03);
      end
      if ((c >= 6) && (c < 15)) chk("t3_level_stalled", s_level[0], 2);
      if (c == 15) chk("t3_resume0", s_data[0], 8'h03);
      if (c == 16) chk("t3_resume1", s_data[0], 8'h04);
    end
    m_ready = 1'b1;

    // Random ready/empty, 1000 words on both latencies.
    src_len = 1000;
    base    = 8'h5A;
    do_reset(2);
    for (int c = 0; c < 8000; c++) begin
      if ((pops[0] == 1000) && (pops[1] == 1000)) break;
      m_ready     = 1'($urandom_range(0, 1));
      force_empty = ($urandom_range(0, 3) == 0);
      tick();
    end
    for (int g = 0; g < NDUT; g++) chk("t4_pops", pops[g], 1000);
    force_empty = 1'b0;

    // Asynchronous reset with reads in flight.
    m_ready = 1'b0;
    src_len = 100;
    base    = 8'h20;
    do_reset(2);
    for (int c = 0; c < 3; c++) tick();
    chk("t5_pre_level0", level[0], 2);
    #2;
    rst_n = 1'b0;
    #1;
    for (int g = 0; g < NDUT; g++) begin
      chk("t5_async_valid", m_valid[g], 0);
      chk("t5_async_level", level[g], 0);
      chk("t5_async_ren", f_ren[g], 0);
    end
    base = 8'h40;
    do_reset(2);
    m_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      for (int g = 0; g < NDUT; g++) begin
        if (c < g + 2) chk("t5_no_early_valid", s_valid[g], 0);
        if (c == g + 2) begin
          chk("t5_first_valid", s_valid[g], 1);
          chk("t5_first_word", s_data[g], 8'h40);
        end
      end
    end

`ifdef FIFO_STREAM_READER_CNT_EN
    // Beat counter and underrun pulses.
    src_len = 300;
    base    = 8'h00;
    m_ready = 1'b1;
    force_empty = 1'b0;
    do_reset(2);
    for (int c = 0; c < 400; c++) begin
      if ((pops[0] == 300) && (pops[1] == 300)) break;
      tick();
    end
    tick();
    for (int g = 0; g < NDUT; g++) chk("t6_beat_cnt", s_beat[g], 300);
    force_empty = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      for (int g = 0; g < NDUT; g++) chk("t6_underrun_on", s_under[g], 1);
    end
    m_ready = 1'b0;
    tick();
    tick();
    for (int g = 0; g < NDUT; g++) chk("t6_underrun_off", s_under[g], 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
